// File: rtl/if_prefetch_pkg.sv
// Shared types for the instruction-fetch stage: IF/ID pipeline register layout,
// fetch FSM state encoding, default prefetch depth and PC alignment helper.
// No logic; imported by if_prefetch and fetch_fifo users.
package pipeline_types;

  localparam int IF_FIFO_DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
  } if_id_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  // Word-align a PC by clearing the two byte-offset bits.
  function automatic logic [31:0] align_pc(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Purpose: generic synchronous FIFO holding prefetched instructions.
// Latency: a push is visible at head one cycle later (no write-to-read bypass).
// Backpressure: push ignored when full unless a pop happens in the same cycle;
//   pop ignored when empty; clr (synchronous) empties the FIFO and wins over push/pop.
// Ports: clk, rst_n (sync active-low), clr, push/push_data, pop, head,
//   full, empty, count (0..DEPTH).
module fetch_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == FULL_CNT);
  assign count   = cnt;
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty && !clr;
  // A full FIFO may still accept a push when the head leaves in the same cycle.
  assign do_push = push && !clr && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset; pointers/count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/if_prefetch.sv
// Purpose: instruction prefetcher - one outstanding memory request at a time,
//   results buffered in a DEPTH-entry FIFO and popped into the IF/ID register oID.
// Latency: redirect at edge N -> oReq after N+1, ack pushes at N+2, oID valid after N+3.
// Backpressure: iStall freezes oID/oValid and the FIFO head; fetching continues
//   until the FIFO is full, then no new request is issued.
// Ports: iClk, nRst (sync active-low), iEn, iFlush, iPCS_EXT/iPC_EXT redirect,
//   iStall, memory side oReq/oAddr/iAck/iData, outputs oValid, oStall (FIFO empty), oID.
module if_prefetch
  import pipeline_types::*;
#(
  parameter int          DEPTH    = IF_FIFO_DEPTH_DEFAULT,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        iClk,
  input  logic        nRst,
  input  logic        iEn,
  input  logic        iFlush,
  input  logic        iPCS_EXT,
  input  logic [31:0] iPC_EXT,
  input  logic        iStall,
  output logic        oReq,
  output logic [31:0] oAddr,
  input  logic        iAck,
  input  logic [31:0] iData,
  output logic        oValid,
  output logic        oStall,
  output if_id_t      oID
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_state_t  state;
  fetch_state_t  state_nxt;
  logic [31:0]   pc;
  logic [31:0]   pc_nxt;
  logic [31:0]   addr_q;
  logic [31:0]   addr_nxt;
  logic [31:0]   redirect_pc;
  logic          can_issue;
  logic          push;
  logic          fifo_push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  if_id_t        push_entry;
  if_id_t        fifo_head;

  assign redirect_pc = align_pc(iPC_EXT);
  assign can_issue   = (fifo_count < DEPTH_C);
  assign push_entry  = '{pc: pc, pc4: pc + 32'd4, instr: iData};
  assign oAddr       = addr_q;
  assign oStall      = fifo_empty;
  assign pop         = !iStall && !iFlush && !fifo_empty;
  // Only one request is ever in flight and it is issued only with a free slot,
  // so this guard never drops a legitimate push; it protects against overwrite.
  assign fifo_push   = push && (!fifo_full || pop);

  always_ff @(posedge iClk) begin
    if (!nRst) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      addr_q <= RESET_PC;
    end else begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      addr_q <= addr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    addr_nxt  = addr_q;
    push      = 1'b0;
    oReq      = 1'b0;
    unique case (state)
      IDLE: begin
        if (iEn && can_issue && !iPCS_EXT) begin
          state_nxt = REQ;
          addr_nxt  = pc;
        end
      end
      REQ: begin
        oReq = 1'b1;
        if (iAck) begin
          state_nxt = IDLE;
          // Redirect or flush in the ack cycle makes this word stale.
          if (!iPCS_EXT && !iFlush) begin
            push   = 1'b1;
            pc_nxt = pc + 32'd4;
          end
        end else if (iPCS_EXT) begin
          state_nxt = DISCARD;
        end
      end
      DISCARD: begin
        // Bus cycle must complete; oAddr stays on the old address and data is dropped.
        oReq = 1'b1;
        if (iAck) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (iPCS_EXT) pc_nxt = redirect_pc;
  end

  always_ff @(posedge iClk) begin
    if (!nRst || iFlush) begin
      oID    <= '0;
      oValid <= 1'b0;
    end else if (!iStall) begin
      if (!fifo_empty) begin
        oID    <= fifo_head;
        oValid <= 1'b1;
      end else begin
        oID    <= '0;
        oValid <= 1'b0;
      end
    end
  end

  fetch_fifo #(
    .WIDTH ($bits(if_id_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (iClk),
    .rst_n     (nRst),
    .clr       (iFlush),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: queue-based reference model updated on posedge,
// compared against the DUT on every negedge, plus directed literal scenarios
// and a randomized phase.
module tb_if_prefetch;
  import pipeline_types::if_id_t;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;

  logic        iClk = 1'b0;
  logic        nRst, iEn, iFlush, iPCS_EXT, iStall, iAck;
  logic [31:0] iPC_EXT, iData;
  logic        oReq, oValid, oStall;
  logic [31:0] oAddr;
  if_id_t      oID;

  if_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .iClk(iClk), .nRst(nRst), .iEn(iEn), .iFlush(iFlush), .iPCS_EXT(iPCS_EXT),
    .iPC_EXT(iPC_EXT), .iStall(iStall), .oReq(oReq), .oAddr(oAddr), .iAck(iAck),
    .iData(iData), .oValid(oValid), .oStall(oStall), .oID(oID)
  );

  always #5 iClk = ~iClk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_pc, m_addr;
  bit          m_busy, m_doomed, m_valid;
  if_id_t      m_id;
  if_id_t      m_q[$];
  if_id_t      m_ne;
  bit          m_pushed, m_was_busy;
  int          m_n0;

  always @(posedge iClk) begin
    if (!nRst) begin
      m_pc = RESET_PC; m_addr = RESET_PC; m_busy = 0; m_doomed = 0;
      m_q.delete(); m_id = '0; m_valid = 0;
    end else begin
      m_was_busy = m_busy;
      m_n0       = m_q.size();
      m_pushed   = 0;
      if (m_was_busy && iAck) begin
        if (!m_doomed && !iPCS_EXT && !iFlush) begin
          m_ne = '{pc: m_pc, pc4: m_pc + 32'd4, instr: iData};
          m_pushed = 1;
          m_pc = m_pc + 32'd4;
        end
        m_busy = 0; m_doomed = 0;
      end else if (m_was_busy && iPCS_EXT) begin
        m_doomed = 1;
      end
      if (iPCS_EXT) m_pc = iPC_EXT & 32'hFFFF_FFFC;
      if (!m_was_busy && iEn && m_n0 < DEPTH && !iPCS_EXT) begin
        m_busy = 1; m_addr = m_pc;
      end
      if (iFlush) begin
        m_q.delete(); m_id = '0; m_valid = 0;
      end else if (!iStall) begin
        if (m_n0 > 0) begin m_id = m_q.pop_front(); m_valid = 1; end
        else begin m_id = '0; m_valid = 0; end
      end
      if (m_pushed) m_q.push_back(m_ne);
    end
  end

  // ---------------- compare process ----------------
  always @(negedge iClk) begin
    if (chk_en) begin
      check("cmp oReq",   oReq,   m_busy);
      check("cmp oAddr",  oAddr,  m_addr);
      check("cmp oValid", oValid, m_valid);
      check("cmp oID",    oID,    m_id);
      check("cmp oStall", oStall, m_q.size() == 0);
    end
  end

  // ---------------- memory responder ----------------
  int ack_mode = 1;      // 0 = automatic responder, 1 = manual
  int ack_lat_max = 0;
  int cur_lat = 0;
  int wait_cnt = 0;

  task automatic drive_ack();
    if (ack_mode != 0) return;
    if (m_busy) begin
      if (wait_cnt >= cur_lat) begin
        iAck = 1; iData = $urandom; wait_cnt = 0;
        cur_lat = $urandom_range(0, ack_lat_max);
      end else begin
        iAck = 0; wait_cnt++;
      end
    end else begin
      iAck = 0; wait_cnt = 0;
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    @(negedge iClk);
    drive_ack();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int          guard, acks;
  bit          seen_poison, done1, done2;
  logic [31:0] a_old, last_addr;

  initial begin
    nRst = 0; iEn = 0; iFlush = 0; iPCS_EXT = 0; iPC_EXT = '0; iStall = 0;
    iAck = 0; iData = '0;
    repeat (2) @(posedge iClk);
    @(negedge iClk);
    chk_en = 1;
    check("rst oReq", oReq, 0);
    check("rst oAddr", oAddr, 32'h100);
    check("rst oValid", oValid, 0);
    check("rst oID", oID, 0);
    check("rst oStall", oStall, 1);

    // Zero-wait fetch sequence from RESET_PC.
    nRst = 1; iEn = 1; ack_mode = 0; ack_lat_max = 0; cur_lat = 0; wait_cnt = 0;
    tick(); check("seq addr0", oAddr, 32'h100); check("seq req0", oReq, 1);
    tick(); check("seq req idle", oReq, 0);
    tick(); check("seq id pc", oID.pc, 32'h100); check("seq id pc4", oID.pc4, 32'h104);
    check("seq id valid", oValid, 1); check("seq addr1", oAddr, 32'h104);
    tick(); tick(); check("seq addr2", oAddr, 32'h108);

    // Stall from reset for 10 cycles: exactly DEPTH acks accepted.
    nRst = 0; iStall = 1; tick(); nRst = 1; iAck = 0; wait_cnt = 0; cur_lat = 0;
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (iAck && oReq) acks++;
      check("stall oID", oID, 0);
      check("stall oValid", oValid, 0);
    end
    check("stall acks", acks, 4);
    check("stall oReq", oReq, 0);
    check("stall oStall", oStall, 0);
    iStall = 0;
    repeat (6) tick();

    // Redirect while a request waits for its ack.
    ack_mode = 1; iAck = 0;
    guard = 0;
    while (!oReq && guard < 20) begin tick(); guard++; end
    check("redir wait oReq", oReq, 1);
    a_old = oAddr;
    iPCS_EXT = 1; iPC_EXT = 32'h2003; tick(); iPCS_EXT = 0;
    check("redir disc req", oReq, 1); check("redir hold0", oAddr, a_old);
    tick(); check("redir hold1", oAddr, a_old);
    tick(); check("redir hold2", oAddr, a_old);
    iAck = 1; iData = 32'hDEAD_BEEF; tick(); iAck = 0;
    check("redir idle", oReq, 0);
    tick(); check("redir new req", oReq, 1); check("redir new addr", oAddr, 32'h2000);
    ack_mode = 0; ack_lat_max = 1; seen_poison = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (oValid && oID.instr == 32'hDEAD_BEEF) seen_poison = 1;
    end
    check("redir dropped data", seen_poison, 0);

    // Flush with 3 entries buffered while stalled.
    ack_lat_max = 0; iFlush = 1; tick(); iFlush = 0;
    guard = 0;
    while (!oValid && guard < 20) begin tick(); guard++; end
    check("flush pre valid", oValid, 1);
    iStall = 1; guard = 0;
    while (m_q.size() != 3 && guard < 30) begin tick(); guard++; end
    check("flush pre fill", oStall, 0);
    iFlush = 1; tick(); iFlush = 0;
    check("flush oValid", oValid, 0); check("flush oID", oID, 0);
    check("flush oStall", oStall, 1);
    iStall = 0;

    // PC wrap at the top of the address space.
    ack_lat_max = 2;
    iPCS_EXT = 1; iPC_EXT = 32'hFFFF_FFFC; tick(); iPCS_EXT = 0;
    done1 = 0; done2 = 0; last_addr = 32'h1;
    for (int i = 0; i < 40 && !(done1 && done2); i++) begin
      tick();
      if (oReq) begin
        if (!done2 && last_addr == 32'hFFFF_FFFC && oAddr != last_addr) begin
          check("wrap next addr", oAddr, 32'h0); done2 = 1;
        end
        last_addr = oAddr;
      end
      if (!done1 && oValid && oID.pc == 32'hFFFF_FFFC) begin
        check("wrap pc4", oID.pc4, 32'h0); done1 = 1;
      end
    end
    check("wrap seen", {done1, done2}, 2'b11);

    // Reset during REQ, ack on the following cycle is ignored.
    ack_mode = 1; iAck = 0; guard = 0;
    while (!oReq && guard < 20) begin tick(); guard++; end
    check("rreq wait oReq", oReq, 1);
    nRst = 0; tick();
    check("rreq oReq", oReq, 0);
    nRst = 1; iEn = 0; iAck = 1; iData = 32'hCAFE_F00D; tick(); iAck = 0;
    check("rreq oValid0", oValid, 0); check("rreq oStall", oStall, 1);
    tick();
    check("rreq oValid1", oValid, 0); check("rreq oReq idle", oReq, 0);

    // Randomized traffic.
    ack_mode = 0; ack_lat_max = 3; iEn = 1;
    for (int i = 0; i < 3000; i++) begin
      iEn      = ($urandom_range(0, 9) != 0);
      iStall   = ($urandom_range(0, 9) < 3);
      iFlush   = ($urandom_range(0, 39) == 0);
      iPCS_EXT = ($urandom_range(0, 24) == 0);
      iPC_EXT  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                             : $urandom;
      nRst     = ($urandom_range(0, 299) != 0);
      tick();
    end
    nRst = 1; iFlush = 0; iPCS_EXT = 0; iStall = 0;
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_prefetch.md
IF_PREFETCH -- requirements
Module: if_prefetch

Interface
REQ-001 Parameter DEPTH, default 4, prefetch FIFO entries; power of two, 2..16.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, fetch PC after reset.
REQ-003 iClk  input  1  sole clock; all state updates on posedge iClk.
REQ-004 nRst  input  1  reset; synchronous, active-low.
REQ-005 iEn  input  1  fetch enable; 0 = issue no new memory requests.
REQ-006 iFlush  input  1  discard FIFO contents and load a bubble into oID.
REQ-007 iPCS_EXT  input  1  redirect strobe; load fetch PC from iPC_EXT.
REQ-008 iPC_EXT  input  32  redirect target.
REQ-009 iStall  input  1  downstream stall; hold oID and oValid.
REQ-010 oReq  output  1  memory request; stays high until iAck.
REQ-011 oAddr  output  32  request address; oAddr[1:0] = 2'b00.
REQ-012 iAck  input  1  memory acknowledge; single-cycle, qualifies iData.
REQ-013 iData  input  32  instruction word.
REQ-014 oValid  output  1  oID holds a real instruction.
REQ-015 oStall  output  1  high when the FIFO is empty.
REQ-016 oID  output  if_id_t  {pc, pc4, instruction} pipeline register.

Function
REQ-017 Fetch PC increments by 4 on each accepted (non-discarded) ack; 32'hFFFF_FFFC wraps to 0.
REQ-018 A redirect loads PC = {iPC_EXT[31:2], 2'b00}; if coincident with an ack, the redirect wins and the ack data is dropped.
REQ-019 FSM states are IDLE, REQ and DISCARD; IDLE->REQ when iEn & (count + 1 <= DEPTH) & ~iPCS_EXT.
REQ-020 In REQ, oReq = 1 and oAddr = PC.
- iAck: push {PC, PC+4, iData} and return to IDLE.
- iPCS_EXT without iAck: go to DISCARD.
REQ-021 In DISCARD, oReq stays 1 and oAddr is held until iAck; that data is dropped and the FSM returns to IDLE. No bus cycle is ever abandoned.
REQ-022 Only one request is outstanding at a time; no request is issued while the FIFO is full.
REQ-023 Output register, when ~iStall:
- FIFO non-empty: pop the head into oID and set oValid = 1.
- FIFO empty: set oID = 0 and oValid = 0.
REQ-024 Output register, when iStall: oID, oValid and the FIFO head are unchanged; fetching continues until the FIFO is full.
REQ-025 A simultaneous push and pop on a full FIFO is legal; on an empty FIFO, the pushed entry is popped next cycle (no bypass).
REQ-026 iFlush empties the FIFO, forces oID = 0 and oValid = 0 regardless of iStall, and drops the same-cycle ack data; PC is unchanged unless iPCS_EXT is also high.
REQ-027 Latency: redirect sampled at edge N gives oReq at cycle N+1; a same-cycle ack pushes at edge N+2; oID is valid after edge N+3.
REQ-028 Falling iEn does not cancel an outstanding request.

Reset
REQ-029 On nRst = 0 at a posedge, the block resets as follows:
- PC = RESET_PC; FSM = IDLE; FIFO empty.
- oReq = 0, oAddr = RESET_PC, oValid = 0, oID = 0, oStall = 1.
REQ-030 Reset mid-REQ drops oReq immediately, and any ack arriving on the following cycle is ignored.

Structure
REQ-031 if_id_t, the fetch_state_t enum (IDLE, REQ, DISCARD) and IF_FIFO_DEPTH_DEFAULT belong in package pipeline_types.
REQ-032 The FIFO is sub-module fetch_fifo (parametrised WIDTH and DEPTH, synchronous clear, push, pop, full, empty, count).

Verification
REQ-033 Reset with RESET_PC = 32'h100 and zero-wait ack -> oAddr sequence 0x100, 0x104, 0x108; oID.pc = 0x100 with pc4 = 0x104 after 3 edges.
REQ-034 iStall held for 10 cycles with DEPTH = 4 -> exactly 4 acks accepted, oReq stays 0 afterwards, and oID is unchanged throughout.
REQ-035 Redirect to 0x2000 while REQ waits 3 cycles for ack -> DISCARD holds the old oAddr until ack, that data never appears in oID, and the next oAddr = 0x2000.
REQ-036 iFlush with the FIFO holding 3 entries and iStall = 1 -> oValid = 0 and oID = 0 next cycle, and oStall = 1.
REQ-037 PC = 0xFFFF_FFFC acked -> next oAddr = 0x0000_0000 and oID.pc4 = 0.
REQ-038 nRst low during REQ, with iAck high on the next cycle -> no push, and oValid remains 0.
